// File: rtl/frame_store_ctrl.sv
// frame_store_ctrl: captures one active VGA frame of RGB332 pixels into BRAM, then replays it in raster order.
// Define FRAME_STORE_CHECKSUM_EN to build the additive checksum of the written frame; otherwise checksum reads 0.
module frame_store_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              store_bram,
    input  logic              capture,
    input  logic              vsync,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic [7:0]        pixel_in,
    output logic [1:0]        bram_state,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [7:0]        bram_din,
    output logic              frame_valid,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_WRITING = 2'b10,
        ST_READING = 2'b11
    } state_t;

    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [7:0]        r_din;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_frame_valid;
    logic              r_vsync_d;
    logic              r_vs_fall;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_we_nxt;
    logic [7:0]        w_din_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] w_rd_base;
    logic              w_in_display;
    logic              w_wr_start;

    assign w_in_display = (hcount < H_LIM) && (vcount < V_LIM);
    assign w_wr_start   = (r_state == ST_CAPTURE) && store_bram && r_vs_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_din         <= '0;
            r_cnt         <= '0;
            r_frame_valid <= 1'b0;
            r_vsync_d     <= 1'b1;
            r_vs_fall     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_we          <= w_we_nxt;
            r_din         <= w_din_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frame_valid <= w_valid_nxt;
            r_vsync_d     <= vsync;
            r_vs_fall     <= r_vsync_d & ~vsync;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_we_nxt    = 1'b0;
        w_din_nxt   = r_din;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_frame_valid;
        w_rd_base   = r_vs_fall ? '0 : r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                w_addr_nxt = '0;
                if (capture && store_bram) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (!store_bram) begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_wr_start) begin
                    w_state_nxt = ST_WRITING;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WRITING: begin
                if (!store_bram) begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_in_display) begin
                    w_we_nxt   = 1'b1;
                    w_din_nxt  = pixel_in;
                    w_addr_nxt = r_cnt;
                    w_cnt_nxt  = r_cnt + ADDR_ONE;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_READING;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            ST_READING: begin
                if (!store_bram) begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                end else begin
                    if (capture) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                    // Saturate at the last stored pixel so replay never reads unwritten space.
                    if (w_in_display) begin
                        w_addr_nxt = w_rd_base;
                        w_cnt_nxt  = (w_rd_base == LAST_ADDR) ? w_rd_base : w_rd_base + ADDR_ONE;
                    end else begin
                        w_cnt_nxt = w_rd_base;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef FRAME_STORE_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_wr_start) begin
            r_checksum <= '0;
        end else if (w_we_nxt) begin
            r_checksum <= r_checksum + {8'h00, pixel_in};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign bram_state  = r_state;
    assign bram_addr   = r_addr;
    assign bram_we     = r_we;
    assign bram_din    = r_din;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_frame_store_ctrl.sv
// tb_frame_store_ctrl: scoreboard bench on an 8x4 active frame inside a 12x7 raster; vsync low on line 5.
module tb_frame_store_ctrl;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int ADDR_W   = 18;
    localparam int H_TOTAL  = 12;
    localparam int V_TOTAL  = 7;
    localparam int VS_LINE  = 5;
    localparam int FRAME_CYCLES = H_TOTAL * V_TOTAL;

`ifdef FRAME_STORE_CHECKSUM_EN
    localparam logic [15:0] EXP_SUM = 16'd496;
`else
    localparam logic [15:0] EXP_SUM = 16'd0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              store_bram;
    logic              capture;
    logic              vsync;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [7:0]        pixel_in;
    logic [1:0]        bram_state;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [7:0]        bram_din;
    logic              frame_valid;
    logic [15:0]       checksum;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                pass_cnt  = 0;
    int                total_cnt = 0;
    int                wr_seen   = 0;
    bit                rd_watch  = 1'b0;
    bit                disp_q    = 1'b0;

    frame_store_ctrl #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .store_bram (store_bram),
        .capture    (capture),
        .vsync      (vsync),
        .hcount     (hcount),
        .vcount     (vcount),
        .pixel_in   (pixel_in),
        .bram_state (bram_state),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_din   (bram_din),
        .frame_valid(frame_valid),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_writes(input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = ADDR_W'(i);
            w.din  = 8'(i);
            exp_wr.push_back(w);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int n = 0;
        while (bram_state !== st && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(bram_state), 32'(st));
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int n = 0;
        while (wr_seen < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(wr_seen), 32'(target));
    endtask

    // Raster generator: pixel value at (h, v) is v*H_ACTIVE + h, i.e. a 0..31 ramp over the active area.
    initial begin
        hcount   = '0;
        vcount   = '0;
        vsync    = 1'b1;
        pixel_in = '0;
        forever begin
            @(posedge clk);
            disp_q = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
            #1;
            if (int'(hcount) == H_TOTAL - 1) begin
                hcount = '0;
                vcount = (int'(vcount) == V_TOTAL - 1) ? '0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
            vsync    = (int'(vcount) != VS_LINE);
            pixel_in = 8'(int'(vcount) * H_ACTIVE + int'(hcount));
        end
    end

    // Monitor: every write pops the write scoreboard; every display cycle while replay is watched pops the read one.
    always @(negedge clk) begin
        wr_t               e;
        logic [ADDR_W-1:0] a;
        if (reset_n === 1'b1 && bram_we === 1'b1) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got write addr=%0d din=%0d, expected no write", bram_addr, bram_din);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(bram_addr), 32'(e.addr));
                check("wr_din", 32'(bram_din), 32'(e.din));
            end
        end
        if (rd_watch && disp_q) begin
            if (exp_rd.size() == 0) begin
                rd_watch = 1'b0;
            end else begin
                a = exp_rd.pop_front();
                check("rd_addr", 32'(bram_addr), 32'(a));
                if (exp_rd.size() == 0) rd_watch = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int n;
        reset_n    = 1'b0;
        store_bram = 1'b0;
        capture    = 1'b0;
        repeat (3) step();
        check("rst_state", 32'(bram_state), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_din", 32'(bram_din), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        reset_n = 1'b1;
        step();

        // Full capture requested mid-frame: must wait for the vsync fall, then write the 32-pixel ramp.
        store_bram = 1'b1;
        while (vcount != 10'd1) step();
        push_writes(32);
        capture = 1'b1;
        step();
        capture = 1'b0;
        check("capture_entry", 32'(bram_state), 32'd1);
        while (vcount != 10'd3) step();
        check("capture_waits", 32'(bram_state), 32'd1);
        check("capture_no_we", 32'(bram_we), 32'd0);
        wait_state(2'b11, 4 * FRAME_CYCLES, "enter_reading");
        check("full_valid", 32'(frame_valid), 32'd1);
        check("full_checksum", 32'(checksum), 32'(EXP_SUM));
        check("full_write_count", 32'(wr_seen), 32'd32);
        check("full_queue_empty", 32'(exp_wr.size()), 32'd0);

        // Replay across two frames: 0..31 each frame, restarting after each vsync fall.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 32; i++) exp_rd.push_back(ADDR_W'(i));
        rd_watch = 1'b1;
        n = 0;
        while (exp_rd.size() != 0 && n < 4 * FRAME_CYCLES) begin
            step();
            n++;
        end
        check("reads_done", 32'(exp_rd.size()), 32'd0);
        rd_watch = 1'b0;
        exp_rd.delete();
        check("read_state", 32'(bram_state), 32'd3);
        check("read_valid", 32'(frame_valid), 32'd1);

        // Capture and store_bram low together while reading: abort wins, frame stays valid.
        capture    = 1'b1;
        store_bram = 1'b0;
        step();
        capture = 1'b0;
        check("abort_rd_state", 32'(bram_state), 32'd0);
        check("abort_rd_valid", 32'(frame_valid), 32'd1);
        check("abort_rd_addr", 32'(bram_addr), 32'd0);

        // New capture aborted after exactly ten writes.
        push_writes(10);
        base       = wr_seen;
        store_bram = 1'b1;
        capture    = 1'b1;
        step();
        capture = 1'b0;
        check("recapture_state", 32'(bram_state), 32'd1);
        check("recapture_valid_kept", 32'(frame_valid), 32'd1);
        wait_wr(base + 10, 4 * FRAME_CYCLES, "ten_writes");
        store_bram = 1'b0;
        step();
        check("abort_wr_state", 32'(bram_state), 32'd0);
        check("abort_wr_valid", 32'(frame_valid), 32'd0);
        check("abort_wr_we", 32'(bram_we), 32'd0);
        repeat (2 * FRAME_CYCLES) step();
        check("abort_no_more_writes", 32'(wr_seen), 32'(base + 10));
        check("abort_queue_empty", 32'(exp_wr.size()), 32'd0);

        // Asynchronous reset during writing: outputs clear without a clock edge.
        push_writes(32);
        store_bram = 1'b1;
        capture    = 1'b1;
        step();
        capture = 1'b0;
        base    = wr_seen;
        wait_wr(base + 3, 4 * FRAME_CYCLES, "three_writes");
        check("we_before_reset", 32'(bram_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_we", 32'(bram_we), 32'd0);
        check("async_state", 32'(bram_state), 32'd0);
        check("async_addr", 32'(bram_addr), 32'd0);
        check("async_din", 32'(bram_din), 32'd0);
        check("async_valid", 32'(frame_valid), 32'd0);
        check("async_checksum", 32'(checksum), 32'd0);
        exp_wr.delete();
        repeat (2) step();
        store_bram = 1'b0;
        reset_n    = 1'b1;
        repeat (2) step();
        check("post_reset_state", 32'(bram_state), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/frame_store_ctrl.md
# frame_store_ctrl

Sequencer for the single-frame BRAM store used by the pixel output path. On a user capture request it waits for a frame boundary, writes one full active frame of packed RGB332 pixels into BRAM, then switches to replaying that frame by generating read addresses in step with VGA timing. It drives the `bram_state` code consumed by the pixel select stage and owns the BRAM address, write-enable and data ports.

## Interface
- `H_ACTIVE`, 640, active pixels per line stored
- `V_ACTIVE`, 400, active lines stored
- `ADDR_W`, 18, BRAM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE

- `clk`  in  1  pixel clock
- `reset_n`  in  1  asynchronous, active-low reset
- `store_bram`  in  1  level switch; enables store/replay mode
- `capture`  in  1  single-cycle debounced capture pulse
- `vsync`  in  1  VGA vsync, active-low
- `hcount`  in  11  VGA horizontal count
- `vcount`  in  10  VGA vertical count
- `pixel_in`  in  8  packed RGB332 pixel aligned with hcount/vcount
- `bram_state`  out  2  00 IDLE, 01 CAPTURE_FRAME, 10 WRITING_FRAME, 11 READING_FRAME
- `bram_addr`  out  ADDR_W  BRAM address (write and read)
- `bram_we`  out  1  BRAM write enable
- `bram_din`  out  8  BRAM write data
- `frame_valid`  out  1  BRAM holds one complete frame
- `checksum`  out  16  additive checksum of last written frame (see Configuration)

## Operation
- `in_display` = hcount < H_ACTIVE && vcount < V_ACTIVE; `vs_fall` = registered vsync 1→0 edge.
- IDLE: bram_we=0, bram_addr=0. `capture && store_bram` → CAPTURE_FRAME.
- CAPTURE_FRAME: wait for `vs_fall` → WRITING_FRAME; clear frame_valid, write counter=0, checksum=0.
- WRITING_FRAME: each cycle with in_display: bram_we=1, bram_din=pixel_in, bram_addr=counter, counter+1, checksum += pixel_in (mod 2^16). On write of address H_ACTIVE*V_ACTIVE-1 → READING_FRAME, frame_valid=1.
- READING_FRAME: bram_we=0. Read counter reset to 0 on `vs_fall`; each in_display cycle bram_addr=counter, counter+1; outside display bram_addr holds. Counter saturates at H_ACTIVE*V_ACTIVE-1 (never wraps into unwritten space). `capture` → CAPTURE_FRAME (frame_valid stays 1 until WRITING entry).
- `store_bram` low in any non-IDLE state → IDLE next cycle; if aborting from CAPTURE_FRAME or WRITING_FRAME, frame_valid=0. Abort from READING_FRAME keeps frame_valid.
- Simultaneous `capture` and `store_bram` low: abort wins. `capture` in CAPTURE_FRAME/WRITING_FRAME ignored.
- No multiplier: addresses come from counters only.

## Timing
- Reset values: bram_state=00, bram_addr=0, bram_we=0, bram_din=0, frame_valid=0, checksum=0.
- All outputs registered. Write: bram_we/addr/din valid 1 cycle after the sampled hcount/vcount/pixel_in.
- Read: bram_addr valid 1 cycle after hcount/vcount; BRAM dout 2 cycles after hcount (consumer compensates).
- State change 1 cycle after the triggering input or `vs_fall`; `vs_fall` itself lags vsync by 1 cycle.
- reset_n assertion mid-write: immediate return to IDLE, bram_we=0 asynchronously.

## Configuration
- `FRAME_STORE_CHECKSUM_EN` defined: checksum accumulates as above, reset on WRITING entry, held afterwards.
- Undefined: no accumulator; `checksum` tied to 0.

## Test plan
- H_ACTIVE=8, V_ACTIVE=4, store_bram=1, capture pulse → CAPTURE_FRAME until vsync falls, then exactly 32 writes at addresses 0..31 with bram_din = pixel_in, then bram_state=11, frame_valid=1.
- Pixel ramp 0..31 with CHECKSUM_EN → checksum=496; without macro checksum=0.
- READING_FRAME across two frames → bram_addr sequence 0..31 each frame, restarting after each vsync fall, bram_we never 1.
- store_bram dropped after 10 writes → IDLE next cycle, frame_valid=0, no further writes.
- capture and store_bram low in same cycle during READING_FRAME → IDLE, frame_valid stays 1.
- reset_n low during WRITING_FRAME → bram_we=0 without clock edge; all outputs at reset values.
